mmio_acc_bridge: RTL and testbench

Memory-mapped bridge directly downstream of the 4-thread pipelined datapath's external memory port. Claims data-memory addresses with addr[9:8] != 0, exposes a control/status register pair, a TX FIFO (datapath to accelerator) and an RX FIFO (accelerator to datapath), and returns load data one cycle after the access, matching the datapath's writeback mux timing. The accelerator side uses valid/ready streams.

---
 rtl/mmio_acc_bridge_if.sv | 14 +
 rtl/mmio_acc_bridge.sv | 102 ++++++++++
 tb/tb_mmio_acc_bridge.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_acc_bridge_if.sv
// mmio_acc_bridge_if: datapath memory port and accelerator valid/ready streams of the MMIO bridge
interface mmio_acc_bridge_if #(parameter int D_WIDTH = 64);
  logic [9:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata, mem_rdata, acc_tx_data, acc_rx_data;
  logic mem_we, mem_re, acc_tx_valid, acc_tx_ready, acc_rx_valid, acc_rx_ready, irq;
  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re, acc_tx_ready, acc_rx_data, acc_rx_valid,
    input mem_rdata, acc_tx_data, acc_tx_valid, acc_rx_ready, irq
  );
  modport slave (
    input mem_addr, mem_wdata, mem_we, mem_re, acc_tx_ready, acc_rx_data, acc_rx_valid,
    output mem_rdata, acc_tx_data, acc_tx_valid, acc_rx_ready, irq
  );
endinterface

// File: rtl/mmio_acc_bridge.sv
// mmio_acc_bridge: CTRL/STATUS registers plus TX/RX FIFOs between the datapath memory port and an accelerator.
// Define ACC_BRIDGE_ERR_STICKY_EN to implement the sticky tx_ovf/rx_udf flags in STATUS[19:18].
module mmio_acc_bridge #(
  parameter int DEPTH = 8,
  parameter int D_WIDTH = 64
) (
  input logic clk,
  input logic reset,
  mmio_acc_bridge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic en, ie, irq_q;
  logic [D_WIDTH-1:0] tx_mem [DEPTH];
  logic [D_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [D_WIDTH-1:0] rdata_q, rd_val, status;
  logic [1:0] region, sel;
  logic tx_ovf, rx_udf, wr_ctrl, flush;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  assign region = bus.mem_addr[9:8];
  assign sel = bus.mem_addr[4:3];
  assign wr_ctrl = bus.mem_we && region == 2'd1 && sel == 2'd0;
  assign flush = wr_ctrl && bus.mem_wdata[1];
  assign tx_full = tx_cnt == CW'(DEPTH);
  assign rx_full = rx_cnt == CW'(DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign rx_empty = rx_cnt == '0;
  assign bus.acc_tx_valid = en && !tx_empty;
  assign bus.acc_rx_ready = en && !rx_full;
  assign bus.acc_tx_data = tx_mem[tx_rd];
  assign bus.mem_rdata = rdata_q;
  assign bus.irq = irq_q;
  // A push into a full TX FIFO is accepted only when the head leaves in the same cycle
  assign tx_pop = bus.acc_tx_valid && bus.acc_tx_ready;
  assign tx_push = bus.mem_we && region == 2'd2 && (!tx_full || tx_pop);
  assign rx_push = bus.acc_rx_valid && bus.acc_rx_ready;
  assign rx_pop = bus.mem_re && region == 2'd3 && !rx_empty;
  assign status = D_WIDTH'({rx_udf, tx_ovf, rx_empty, tx_full, 8'(rx_cnt), 8'(tx_cnt)});
  assign rd_val = (region == 2'd1 && sel == 2'd0) ? D_WIDTH'({ie, 1'b0, en}) :
                  (region == 2'd1 && sel == 2'd1) ? status :
                  (region == 2'd3 && !rx_empty) ? rx_mem[rx_rd] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      en <= 1'b0;
      ie <= 1'b0;
      irq_q <= 1'b0;
      rdata_q <= '0;
      tx_wr <= '0;
      tx_rd <= '0;
      tx_cnt <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
      rx_cnt <= '0;
    end else begin
      if (wr_ctrl) begin
        en <= bus.mem_wdata[0];
        ie <= bus.mem_wdata[2];
      end
      irq_q <= ie && !rx_empty;
      if (bus.mem_re && region != 2'd0) rdata_q <= rd_val;
      if (flush) begin
        tx_wr <= '0;
        tx_rd <= '0;
        tx_cnt <= '0;
        rx_wr <= '0;
        rx_rd <= '0;
        rx_cnt <= '0;
      end else begin
        if (tx_push) tx_wr <= tx_wr + 1'b1;
        if (tx_pop) tx_rd <= tx_rd + 1'b1;
        if (rx_push) rx_wr <= rx_wr + 1'b1;
        if (rx_pop) rx_rd <= rx_rd + 1'b1;
        tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
        rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.mem_wdata;
    if (rx_push) rx_mem[rx_wr] <= bus.acc_rx_data;
  end
`ifdef ACC_BRIDGE_ERR_STICKY_EN
  logic wr_stat;
  assign wr_stat = bus.mem_we && region == 2'd1 && sel == 2'd1;
  // Setting takes priority over a same-cycle W1C clear
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      tx_ovf <= (bus.mem_we && region == 2'd2 && tx_full && !tx_pop) || (tx_ovf && !(wr_stat && bus.mem_wdata[18]));
      rx_udf <= (bus.mem_re && region == 2'd3 && rx_empty) || (rx_udf && !(wr_stat && bus.mem_wdata[19]));
    end
  end
`else
  assign tx_ovf = 1'b0;
  assign rx_udf = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_acc_bridge.sv
// tb_mmio_acc_bridge: directed stimulus with scoreboard queues for load data and TX stream words.
module tb_mmio_acc_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_tx[$];
  logic ld_q = 1'b0;
`ifdef ACC_BRIDGE_ERR_STICKY_EN
  localparam logic [63:0] OVF = 64'h40000;
  localparam logic [63:0] UDF = 64'h80000;
`else
  localparam logic [63:0] OVF = 64'h0;
  localparam logic [63:0] UDF = 64'h0;
`endif

  mmio_acc_bridge_if #(.D_WIDTH(64)) bus();
  mmio_acc_bridge #(.DEPTH(8), .D_WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) ld_q <= bus.mem_re && (bus.mem_addr[9:8] != 2'b00) && !reset;

  always @(negedge clk) begin
    if (ld_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_extra got=%h exp=none", bus.mem_rdata);
      end else chk("rdata", bus.mem_rdata, exp_q.pop_front());
    end
    if (bus.acc_tx_valid && bus.acc_tx_ready) begin
      if (exp_tx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_extra got=%h exp=none", bus.acc_tx_data);
      end else chk("tx_data", bus.acc_tx_data, exp_tx.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [9:0] a, input logic [63:0] d);
    bus.mem_addr = a;
    bus.mem_wdata = d;
    bus.mem_we = 1'b1;
    idle(1);
    bus.mem_we = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, input logic [63:0] e);
    bus.mem_addr = a;
    bus.mem_re = 1'b1;
    exp_q.push_back(e);
    idle(1);
    bus.mem_re = 1'b0;
  endtask

  task automatic rx_send(input logic [63:0] d);
    bus.acc_rx_data = d;
    bus.acc_rx_valid = 1'b1;
    idle(1);
    bus.acc_rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.mem_we = 1'b0;
    bus.mem_re = 1'b0;
    bus.acc_tx_ready = 1'b0;
    bus.acc_rx_data = '0;
    bus.acc_rx_valid = 1'b0;
    idle(3);
    reset = 1'b0;
    chk("rst_tx_valid", 64'(bus.acc_tx_valid), 0);
    chk("rst_rx_ready", 64'(bus.acc_rx_ready), 0);
    chk("rst_irq", 64'(bus.irq), 0);
    chk("rst_rdata", bus.mem_rdata, 0);
    load(10'h108, 64'h20000);
    // TX path
    store(10'h100, 64'h1);
    store(10'h200, 64'hA5);
    exp_tx.push_back(64'hA5);
    store(10'h200, 64'h5A);
    exp_tx.push_back(64'h5A);
    load(10'h108, 64'h20002);
    chk("tx_head", bus.acc_tx_data, 64'hA5);
    chk("tx_valid_pend", 64'(bus.acc_tx_valid), 1);
    bus.acc_tx_ready = 1'b1;
    idle(2);
    bus.acc_tx_ready = 1'b0;
    chk("tx_valid_drained", 64'(bus.acc_tx_valid), 0);
    // RX path with interrupt
    store(10'h100, 64'h5);
    chk("rx_ready_en", 64'(bus.acc_rx_ready), 1);
    rx_send(64'h11);
    rx_send(64'h22);
    chk("irq_set", 64'(bus.irq), 1);
    load(10'h300, 64'h11);
    load(10'h300, 64'h22);
    chk("irq_lag", 64'(bus.irq), 1);
    load(10'h300, 64'h0);
    chk("irq_clear", 64'(bus.irq), 0);
    load(10'h108, 64'h20000 | UDF);
    store(10'h108, 64'h80000);
    load(10'h108, 64'h20000);
    // TX overflow
    for (int i = 0; i < 8; i++) begin
      store(10'h200, 64'h100 + 64'(i));
      exp_tx.push_back(64'h100 + 64'(i));
    end
    store(10'h2F0, 64'hDEAD);
    load(10'h108, 64'h30008 | OVF);
    store(10'h108, 64'h40000);
    load(10'h108, 64'h30008);
    bus.acc_tx_ready = 1'b1;
    idle(8);
    bus.acc_tx_ready = 1'b0;
    chk("tx_valid_after_fill", 64'(bus.acc_tx_valid), 0);
    // RX full with a same-cycle pop and pending push
    for (int i = 0; i < 8; i++) rx_send(64'h1000 + 64'(i));
    chk("rx_ready_full", 64'(bus.acc_rx_ready), 0);
    load(10'h108, 64'h800);
    bus.acc_rx_data = 64'h2000;
    bus.acc_rx_valid = 1'b1;
    load(10'h300, 64'h1000);
    chk("rx_ready_after_pop", 64'(bus.acc_rx_ready), 1);
    idle(1);
    bus.acc_rx_valid = 1'b0;
    load(10'h108, 64'h800);
    for (int i = 1; i < 8; i++) load(10'h3C8, 64'h1000 + 64'(i));
    load(10'h300, 64'h2000);
    load(10'h108, 64'h20000);
    // Flush with transfers pending
    store(10'h200, 64'hF0);
    store(10'h200, 64'hF1);
    store(10'h200, 64'hF2);
    rx_send(64'h44);
    rx_send(64'h55);
    bus.acc_rx_data = 64'h3333;
    bus.acc_rx_valid = 1'b1;
    store(10'h100, 64'h3);
    bus.acc_rx_valid = 1'b0;
    chk("flush_tx_valid", 64'(bus.acc_tx_valid), 0);
    load(10'h108, 64'h20000);
    load(10'h100, 64'h1);
    load(10'h300, 64'h0);
    store(10'h200, 64'h77);
    exp_tx.push_back(64'h77);
    bus.acc_tx_ready = 1'b1;
    idle(2);
    bus.acc_tx_ready = 1'b0;
    // Reset mid-transfer and region-0 decode
    store(10'h200, 64'h99);
    store(10'h200, 64'h98);
    rx_send(64'h66);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rst2_tx_valid", 64'(bus.acc_tx_valid), 0);
    chk("rst2_irq", 64'(bus.irq), 0);
    chk("rst2_rdata", bus.mem_rdata, 0);
    load(10'h108, 64'h20000);
    bus.mem_addr = 10'h0F8;
    bus.mem_re = 1'b1;
    idle(1);
    bus.mem_re = 1'b0;
    chk("region0_hold", bus.mem_rdata, 64'h20000);
    store(10'h000, 64'h1);
    load(10'h100, 64'h0);
    load(10'h110, 64'h0);
    idle(2);
    chk("rdata_queue_empty", 64'(exp_q.size()), 0);
    chk("tx_queue_empty", 64'(exp_tx.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
